regfile_wb_sink: RTL and testbench

//  Receiving end of the writeback (stage-5) interface: register file that consumes

---
 rtl/regfile_wb_sink.sv | 54 +++++
 tb/tb_regfile_wb_sink.sv | 123 ++++++++++++
 2 files changed

// File: rtl/regfile_wb_sink.sv
// regfile_wb_sink: writeback-side register file with bypassed read ports and an in-flight scoreboard
module regfile_wb_sink #(
  parameter int Width = 32,
  parameter int AddrW = 5,
  parameter int CntW  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RegWrite,
  input  logic [AddrW-1:0] rd,
  input  logic [Width-1:0] Writeback,
  input  logic [AddrW-1:0] rs1,
  input  logic [AddrW-1:0] rs2,
  output logic [Width-1:0] rd1,
  output logic [Width-1:0] rd2,
  input  logic             issue_valid,
  input  logic             issue_regwrite,
  input  logic [AddrW-1:0] issue_rd,
  output logic             stall,
  output logic             wb_underflow
);
  localparam int Depth = 2 ** AddrW;
  localparam logic [CntW-1:0] Max = '1;
  logic [Width-1:0] regs [Depth];
  logic [CntW-1:0]  cnt  [Depth];
  logic [Depth-1:0] retire, inc, busy, zero;
  logic accept;
  for (genvar i = 0; i < Depth; i++) begin : g_reg
    assign retire[i] = RegWrite && rd == AddrW'(i) && i != 0;
    assign inc[i]    = accept && issue_regwrite && issue_rd == AddrW'(i) && i != 0;
    // a register retiring this cycle is already treated as clear
    assign busy[i]   = (cnt[i] - CntW'(retire[i])) != '0;
    assign zero[i]   = cnt[i] == '0;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end else begin
        if (retire[i]) regs[i] <= Writeback;
        if (inc[i] && !retire[i] && cnt[i] != Max) cnt[i] <= cnt[i] + 1'b1;
        else if (retire[i] && !inc[i] && !zero[i]) cnt[i] <= cnt[i] - 1'b1;
      end
  end
  always_comb begin
    rd1    = !rst_n || rs1 == '0 ? '0 : (RegWrite && rd == rs1) ? Writeback : regs[rs1];
    rd2    = !rst_n || rs2 == '0 ? '0 : (RegWrite && rd == rs2) ? Writeback : regs[rs2];
    stall  = issue_valid && (busy[rs1] || busy[rs2] ||
             (issue_regwrite && issue_rd != '0 && cnt[issue_rd] == Max && !retire[issue_rd]));
    accept = issue_valid && !stall;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wb_underflow <= 1'b0;
    else if (|(retire & ~inc & zero)) wb_underflow <= 1'b1;
endmodule

// File: tb/tb_regfile_wb_sink.sv
// tb_regfile_wb_sink: directed scoreboard bench for the writeback-side register file
module tb_regfile_wb_sink;
  logic        clk = 1'b0;
  logic        rst_n, RegWrite, issue_valid, issue_regwrite, stall, wb_underflow;
  logic [4:0]  rd, rs1, rs2, issue_rd;
  logic [31:0] Writeback, rd1, rd2;
  int checks = 0, failures = 0;
  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  regfile_wb_sink dut (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .rd(rd), .Writeback(Writeback),
    .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2), .issue_valid(issue_valid),
    .issue_regwrite(issue_regwrite), .issue_rd(issue_rd), .stall(stall),
    .wb_underflow(wb_underflow)
  );

  always #5 clk = ~clk;

  task automatic exp(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic [31:0] obs;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = e.sel == 0 ? rd1 : e.sel == 1 ? rd2 : e.sel == 2 ? {31'b0, stall} : {31'b0, wb_underflow};
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    RegWrite = 0; rd = 0; Writeback = 0; rs1 = 0; rs2 = 0;
    issue_valid = 0; issue_regwrite = 0; issue_rd = 0;
  endtask

  task automatic issue(input logic [4:0] r);
    issue_valid = 1; issue_regwrite = 1; issue_rd = r;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    RegWrite = 1; rd = r; Writeback = d;
  endtask

  initial begin
    rst_n = 0;
    RegWrite = 0; rd = 0; Writeback = 0; rs1 = 0; rs2 = 0;
    issue_valid = 0; issue_regwrite = 0; issue_rd = 0;
    nxt(); exp("reset_stall", 2, 0); exp("reset_uf", 3, 0); check_all();
    nxt(); rst_n = 1;
    // retire of an idle register sets the sticky flag
    nxt(); wb(4, 32'h1); exp("uf_pre", 3, 0); check_all();
    nxt(); exp("uf_set", 3, 1); check_all();
    // build x5 = DEADBEEF with two writes in flight, then reset asynchronously
    nxt(); issue(5);
    nxt(); issue(5);
    nxt(); wb(5, 32'hDEADBEEF);
    nxt(); issue(5);
    nxt(); rs1 = 5; issue_valid = 1;
    exp("x5_loaded", 0, 32'hDEADBEEF); exp("x5_busy", 2, 1); check_all();
    rst_n = 0;
    exp("async_rd1", 0, 0); exp("async_stall", 2, 0); exp("async_uf", 3, 0); check_all();
    nxt(); rst_n = 1; rs1 = 5; issue_valid = 1;
    exp("post_rst_rd1", 0, 0); exp("post_rst_stall", 2, 0); check_all();
    // write/read with bypass
    nxt(); issue(3);
    nxt(); wb(3, 32'h12345678); rs1 = 3; exp("bypass", 0, 32'h12345678); check_all();
    nxt(); rs1 = 3; exp("array_rd", 0, 32'h12345678); exp("no_uf", 3, 0); check_all();
    // x0 is hardwired and never tracked
    nxt(); wb(0, 32'hFFFFFFFF); issue(0);
    exp("x0_rd", 0, 0); exp("x0_stall0", 2, 0); check_all();
    nxt(); issue(0); exp("x0_stall1", 2, 0); check_all();
    nxt(); issue(0); exp("x0_stall2", 2, 0); check_all();
    nxt(); issue(0); exp("x0_stall3", 2, 0); exp("x0_rd_after", 0, 0); exp("x0_no_uf", 3, 0); check_all();
    // RAW hazard cleared by a same-cycle retire
    nxt(); issue(7); exp("raw_issue", 2, 0); check_all();
    nxt(); issue_valid = 1; rs2 = 7; exp("raw_stall", 2, 1); check_all();
    nxt(); issue(8); rs2 = 7; wb(7, 32'hA5A50007);
    exp("raw_clear", 2, 0); exp("raw_bypass", 1, 32'hA5A50007); check_all();
    nxt(); issue_valid = 1; rs1 = 8; rs2 = 7;
    exp("raw_accepted", 2, 1); exp("raw_array", 1, 32'hA5A50007); check_all();
    nxt(); rs1 = 8; exp("idle_no_stall", 2, 0); check_all();
    // counter saturation
    nxt(); issue(9); exp("sat_i1", 2, 0); check_all();
    nxt(); issue(9); exp("sat_i2", 2, 0); check_all();
    nxt(); issue(9); exp("sat_i3", 2, 0); check_all();
    nxt(); issue(9); exp("sat_full", 2, 1); check_all();
    nxt(); issue(9); wb(9, 32'h9); exp("sat_retire", 2, 0); check_all();
    nxt(); issue(9); exp("sat_still_full", 2, 1); check_all();
    // simultaneous issue and retire leaves the count unchanged
    nxt(); issue(6);
    nxt(); issue(6); wb(6, 32'h66); exp("sim_accept", 2, 0); check_all();
    nxt(); issue_valid = 1; rs1 = 6; exp("sim_still_busy", 2, 1); check_all();
    nxt(); issue_valid = 1; rs1 = 6; wb(6, 32'h67); exp("sim_retire_clear", 2, 0); check_all();
    nxt(); issue_valid = 1; rs1 = 6; exp("sim_idle", 2, 0); exp("sim_rd1", 0, 32'h67); check_all();
    // sticky underflow
    nxt(); wb(4, 32'h4); exp("uf2_pre", 3, 0); check_all();
    nxt(); exp("uf2_set", 3, 1); check_all();
    nxt(); exp("uf2_sticky", 3, 1); check_all();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
